// File: rtl/wb_traffic_master.sv
// Wishbone classic-cycle traffic master: writes COUNT pattern words, reads them back, counts mismatches.
// Latency: start sampled at edge t puts cyc/stb on the bus from t+1; zero-wait run is 6*COUNT+1 cycles.
// Backpressure: stb/adr/dat_w are held until ack; a watchdog aborts the run after TIMEOUT unacked cycles.
//
// Ports:
//   sys_clk, sys_rst_n   clock and asynchronous active-low reset
//   start                one-cycle run request, honoured only in IDLE
//   adr/dat_w/we/sel     Wishbone request (word address, write data, direction, byte select)
//   cyc/stb/ack/dat_r    Wishbone handshake and read data
//   busy/done/timeout    run status: busy during the run, done pulse at the end, sticky timeout flag
//   err_count            saturating count of readback mismatches
module wb_traffic_master #(
    parameter int unsigned ID      = 0,
    parameter logic [29:0] BASE    = 30'h0,
    parameter int unsigned COUNT   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    output logic [29:0] adr,
    output logic [31:0] dat_w,
    input  logic [31:0] dat_r,
    output logic        we,
    output logic [3:0]  sel,
    output logic        cyc,
    output logic        stb,
    input  logic        ack,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] err_count
);

    localparam logic [7:0]  ID_BYTE  = 8'(ID);
    localparam logic [15:0] LAST_IDX = 16'(COUNT - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WGAP,
        S_RD,
        S_RGAP,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [15:0] idx_q;
    logic [15:0] wdog_q;
    logic [29:0] adr_q;
    logic [31:0] dat_w_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic        cyc_q;
    logic        stb_q;
    logic        busy_q;
    logic        done_q;
    logic        timeout_q;
    logic [15:0] err_q;

    // Address and pattern for the current index; loaded into the bus
    // registers whenever a transfer is (re)launched.
    logic [29:0] adr_d;
    logic [31:0] dat_w_d;
    logic [15:0] idx_inc;
    logic        idx_last;
    logic        rd_mismatch;

    always_comb begin
        adr_d       = BASE + {14'd0, idx_q};
        dat_w_d     = {ID_BYTE, 8'hC3, idx_q};
        idx_inc     = idx_q + 16'd1;
        idx_last    = (idx_q == LAST_IDX);
        rd_mismatch = (dat_r != dat_w_d);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= 16'd0;
            wdog_q    <= 16'd0;
            adr_q     <= 30'd0;
            dat_w_q   <= 32'd0;
            we_q      <= 1'b0;
            sel_q     <= 4'h0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 16'd0;
        end else begin
            // done is a single-cycle pulse; only the finishing branches raise it
            done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_WR;
                        idx_q     <= 16'd0;
                        wdog_q    <= 16'd0;
                        err_q     <= 16'd0;
                        timeout_q <= 1'b0;
                        adr_q     <= BASE;
                        dat_w_q   <= {ID_BYTE, 8'hC3, 16'd0};
                        we_q      <= 1'b1;
                        sel_q     <= 4'hF;
                        cyc_q     <= 1'b1;
                        stb_q     <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end

                S_WR, S_RD: begin
                    if (ack) begin
                        if (state_q == S_RD && rd_mismatch && err_q != 16'hFFFF) begin
                            err_q <= err_q + 16'd1;
                        end
                        // every acked transfer is followed by one stb-low cycle
                        stb_q <= 1'b0;
                        sel_q <= 4'h0;
                        if (!idx_last) begin
                            idx_q   <= idx_inc;
                            state_q <= (state_q == S_WR) ? S_WGAP : S_RGAP;
                        end else if (state_q == S_WR) begin
                            // write phase complete: restart the index for readback
                            idx_q   <= 16'd0;
                            we_q    <= 1'b0;
                            state_q <= S_RGAP;
                        end else begin
                            idx_q   <= 16'd0;
                            we_q    <= 1'b0;
                            cyc_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end else if (wdog_q == TMO_LAST) begin
                        // stb has now been high TIMEOUT cycles without ack: abandon the run
                        timeout_q <= 1'b1;
                        stb_q     <= 1'b0;
                        sel_q     <= 4'h0;
                        we_q      <= 1'b0;
                        cyc_q     <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
                end

                S_WGAP: begin
                    state_q <= S_WR;
                    wdog_q  <= 16'd0;
                    adr_q   <= adr_d;
                    dat_w_q <= dat_w_d;
                    we_q    <= 1'b1;
                    sel_q   <= 4'hF;
                    stb_q   <= 1'b1;
                end

                S_RGAP: begin
                    state_q <= S_RD;
                    wdog_q  <= 16'd0;
                    adr_q   <= adr_d;
                    we_q    <= 1'b0;
                    sel_q   <= 4'hF;
                    stb_q   <= 1'b1;
                end

                S_DONE: begin
                    // start arriving here is deliberately dropped
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                    cyc_q   <= 1'b0;
                    stb_q   <= 1'b0;
                    sel_q   <= 4'h0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign adr       = adr_q;
    assign dat_w     = dat_w_q;
    assign we        = we_q;
    assign sel       = sel_q;
    assign cyc       = cyc_q;
    assign stb       = stb_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_wb_traffic_master.sv
// Bench for wb_traffic_master: two instances (plain and address-wrapping) share one slave model.
// Expected bus transfers are queued when a run is started and popped as the DUT completes them.
// Slave modes: 0 zero-wait memory, 1 random ack delay, 2 corrupt read of index 2, 3 never ack.
module tb_wb_traffic_master;

    localparam logic [29:0] BASE_A = 30'h100;
    localparam logic [29:0] BASE_B = 30'h3FFF_FFFF;
    localparam logic [7:0]  ID_A   = 8'h05;
    localparam logic [7:0]  ID_B   = 8'hA7;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic sys_rst_n;
    logic st;
    int   which;
    int   mode;

    logic        start_a, start_b, ack_a, ack_b;
    logic [29:0] adr_a, adr_b;
    logic [31:0] dat_w_a, dat_w_b;
    logic        we_a, we_b, cyc_a, cyc_b, stb_a, stb_b;
    logic [3:0]  sel_a, sel_b;
    logic        busy_a, busy_b, done_a, done_b, to_a, to_b;
    logic [15:0] err_a, err_b;
    logic [31:0] dat_r;

    // selected-master view of the bus
    logic [29:0] s_adr;
    logic [31:0] s_dat_w;
    logic        s_we, s_cyc, s_stb, s_busy, s_done, s_to, s_ack;
    logic [3:0]  s_sel;
    logic [15:0] s_err;

    wb_traffic_master #(.ID(32'h05), .BASE(BASE_A), .COUNT(4), .TIMEOUT(10)) u_dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_a),
        .adr(adr_a), .dat_w(dat_w_a), .dat_r(dat_r), .we(we_a), .sel(sel_a),
        .cyc(cyc_a), .stb(stb_a), .ack(ack_a), .busy(busy_a), .done(done_a),
        .timeout(to_a), .err_count(err_a)
    );

    wb_traffic_master #(.ID(32'hA7), .BASE(BASE_B), .COUNT(2), .TIMEOUT(255)) u_dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_b),
        .adr(adr_b), .dat_w(dat_w_b), .dat_r(dat_r), .we(we_b), .sel(sel_b),
        .cyc(cyc_b), .stb(stb_b), .ack(ack_b), .busy(busy_b), .done(done_b),
        .timeout(to_b), .err_count(err_b)
    );

    assign start_a = st && (which == 0);
    assign start_b = st && (which == 1);
    assign ack_a   = s_ack && (which == 0);
    assign ack_b   = s_ack && (which == 1);

    always_comb begin
        if (which == 0) begin
            s_adr = adr_a; s_dat_w = dat_w_a; s_we = we_a; s_sel = sel_a; s_cyc = cyc_a;
            s_stb = stb_a; s_busy = busy_a; s_done = done_a; s_to = to_a; s_err = err_a;
        end else begin
            s_adr = adr_b; s_dat_w = dat_w_b; s_we = we_b; s_sel = sel_b; s_cyc = cyc_b;
            s_stb = stb_b; s_busy = busy_b; s_done = done_b; s_to = to_b; s_err = err_b;
        end
    end

    // ---------------- slave model: registered ack, 16-word memory ----------------
    logic [31:0] mem [16];
    int          wait_cnt;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s_ack    <= 1'b0;
            wait_cnt <= 0;
        end else if (s_ack) begin
            s_ack <= 1'b0;
        end else if (s_stb && mode != 3) begin
            if (mode == 1 && wait_cnt < 5 && $urandom_range(0, 2) != 0) begin
                wait_cnt <= wait_cnt + 1;
            end else begin
                s_ack    <= 1'b1;
                wait_cnt <= 0;
                if (s_we) mem[s_adr[3:0]] <= s_dat_w;
                else dat_r <= mem[s_adr[3:0]] ^
                              ((mode == 2 && s_adr == BASE_A + 30'd2) ? 32'h0000_0100 : 32'h0);
            end
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endfunction

    function automatic void chk_rng(input string nm, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endfunction

    typedef struct {
        logic        we;
        logic [29:0] adr;
        logic [31:0] dat;
    } xfer_t;

    xfer_t exp_q[$];

    // monitor: scoreboard pops, stb stability and one-cycle gaps
    int          nxfer, stb_cyc, stab_err, gap_err, gap_len, done_cnt;
    logic        p_stb, p_ack, p_we;
    logic [29:0] p_adr;
    logic [31:0] p_dat;

    initial begin
        xfer_t e;
        p_stb = 1'b0; p_ack = 1'b0; p_we = 1'b0; p_adr = '0; p_dat = '0;
        gap_len = 0;
        forever begin
            @(negedge sys_clk);
            if (s_stb) stb_cyc++;
            if (s_done) done_cnt++;
            if (s_stb && p_stb && !p_ack &&
                (s_adr != p_adr || s_we != p_we || s_dat_w != p_dat)) stab_err++;
            if (s_stb && p_stb && p_ack) gap_err++;
            if (s_stb && !p_stb && gap_len > 1) gap_err++;
            if (s_stb && s_sel != 4'hF) stab_err++;
            if (!s_stb && s_sel != 4'h0) stab_err++;
            if (s_cyc && !s_stb) gap_len++;
            if (s_stb || !s_cyc) gap_len = 0;
            if (s_stb && s_ack) begin
                nxfer++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("xfer_we", 32'(s_we), 32'(e.we));
                    chk("xfer_adr", 32'(s_adr), 32'(e.adr));
                    if (e.we) chk("xfer_wdat", s_dat_w, e.dat);
                end
            end
            p_stb = s_stb; p_ack = s_ack; p_we = s_we; p_adr = s_adr; p_dat = s_dat_w;
        end
    end

    typedef struct {
        int which;
        int mode;
        int exp_err;
        int exp_to;
        int exp_xfer;
        int cyc_lo;
        int cyc_hi;
        int stb_lo;
        int stb_hi;
    } vec_t;

    vec_t vecs[6];

    // Starts one run from just after a negedge and checks it to completion.
    // Cycle count is inclusive: the cycle start is sampled in through the done cycle.
    task automatic run_vec(input vec_t v, input int hold, input bit poke_busy);
        int          ncyc;
        int          idle_cyc;
        bit          seen;
        bit          prev_busy;
        logic [29:0] base;
        logic [7:0]  id;
        xfer_t       e;
        which = v.which;
        mode  = v.mode;
        base  = (v.which == 0) ? BASE_A : BASE_B;
        id    = (v.which == 0) ? ID_A : ID_B;
        exp_q.delete();
        for (int i = 0; i < v.exp_xfer / 2; i++) begin
            e.we = 1'b1; e.adr = base + 30'(i); e.dat = {id, 8'hC3, 16'(i)};
            exp_q.push_back(e);
        end
        for (int i = 0; i < v.exp_xfer / 2; i++) begin
            e.we = 1'b0; e.adr = base + 30'(i); e.dat = 32'd0;
            exp_q.push_back(e);
        end
        nxfer = 0; stb_cyc = 0; stab_err = 0; gap_err = 0; done_cnt = 0;
        st = 1'b1; ncyc = 1; seen = 1'b0; prev_busy = 1'b0;
        while (!seen && ncyc < 400) begin
            @(negedge sys_clk);
            ncyc++;
            if (ncyc > hold) st = 1'b0;
            if (poke_busy && ncyc == 8) st = 1'b1;
            if (ncyc == 2) begin
                chk("stb_after_start", 32'({s_cyc, s_stb}), 32'h3);
                chk("busy_after_start", 32'(s_busy), 32'h1);
                chk("timeout_cleared", 32'(s_to), 32'h0);
            end
            if (s_done) seen = 1'b1;
            else prev_busy = s_busy;
        end
        chk("done_seen", 32'(seen), 32'h1);
        chk_rng("run_cycles", ncyc, v.cyc_lo, v.cyc_hi);
        chk("busy_at_done", 32'(s_busy), 32'h0);
        chk("busy_before_done", 32'(prev_busy), 32'h1);
        chk("cyc_at_done", 32'(s_cyc), 32'h0);
        chk("err_count", 32'(s_err), 32'(v.exp_err));
        chk("timeout", 32'(s_to), 32'(v.exp_to));
        // start during the DONE cycle must not launch a new run
        st = 1'b1;
        idle_cyc = 0;
        repeat (6) begin
            @(negedge sys_clk);
            st = 1'b0;
            if (s_cyc) idle_cyc++;
        end
        chk("idle_after_done", 32'(idle_cyc), 32'h0);
        chk("timeout_sticky", 32'(s_to), 32'(v.exp_to));
        chk("done_pulses", 32'(done_cnt), 32'h1);
        chk("xfer_count", 32'(nxfer), 32'(v.exp_xfer));
        chk("sb_left", 32'(exp_q.size()), 32'h0);
        chk_rng("stb_cycles", stb_cyc, v.stb_lo, v.stb_hi);
        chk("stb_stable", 32'(stab_err), 32'h0);
        chk("stb_gaps", 32'(gap_err), 32'h0);
    endtask

    initial begin
        //          which mode err to xfer cyc_lo cyc_hi stb_lo stb_hi
        vecs[0] = '{0, 0, 0, 0, 8, 25, 25, 16, 16};   // zero-wait memory
        vecs[1] = '{0, 1, 0, 0, 8, 25, 66, 16, 56};   // random ack delay
        vecs[2] = '{0, 2, 1, 0, 8, 25, 25, 16, 16};   // read index 2 corrupted
        vecs[3] = '{0, 3, 0, 1, 0, 12, 12, 10, 10};   // never acks, TIMEOUT=10
        vecs[4] = '{0, 0, 0, 0, 8, 25, 25, 16, 16};   // new start clears timeout
        vecs[5] = '{1, 0, 0, 0, 4, 13, 13, 8, 8};     // BASE wraps past 30'h3FFFFFFF

        sys_rst_n = 1'b0;
        st        = 1'b0;
        which     = 0;
        mode      = 0;
        repeat (3) @(negedge sys_clk);
        chk("rst_a_ctrl", 32'({we_a, sel_a, cyc_a, stb_a, busy_a, done_a, to_a}), 32'h0);
        chk("rst_a_adr", 32'(adr_a), 32'h0);
        chk("rst_a_dat", dat_w_a, 32'h0);
        chk("rst_a_err", 32'(err_a), 32'h0);
        chk("rst_b_ctrl", 32'({we_b, sel_b, cyc_b, stb_b, busy_b, done_b, to_b}), 32'h0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], 1, 1'b0);

        // reset asserted mid-write with stb high drops the bus immediately
        which = 0;
        mode  = 3;
        st    = 1'b1;
        @(negedge sys_clk);
        st = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("pre_rst_stb", 32'({s_cyc, s_stb, s_we}), 32'h7);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", 32'({we_a, sel_a, cyc_a, stb_a, busy_a, done_a, to_a}), 32'h0);
        chk("mid_rst_adr", 32'(adr_a), 32'h0);
        chk("mid_rst_dat", dat_w_a, 32'h0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        // rerun must start again from index 0 (scoreboard starts at BASE_A)
        run_vec(vecs[0], 1, 1'b0);

        // start held 3 cycles plus a start pulse while busy: exactly one run
        run_vec(vecs[0], 3, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
